// File: rtl/wb_gpio_irq_if.sv
// ----------------------------------------------------------------------------
// wb_gpio_irq_if
// Wishbone classic slave bus bundle for the GPIO peripheral.
//   wb_adr_i  : byte address from the master (only [4:2] decoded by the slave)
//   wb_dat_i  : write data from the master
//   wb_sel_i  : byte lane enables
//   wb_we_i   : write enable
//   wb_cyc_i  : bus cycle in progress
//   wb_stb_i  : strobe / request
//   wb_dat_o  : registered read data from the slave
//   wb_ack_o  : transfer acknowledge from the slave
// Signal names keep the slave's point of view (_i = into slave).
// ----------------------------------------------------------------------------
interface wb_gpio_irq_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_gpio_irq.sv
// ----------------------------------------------------------------------------
// wb_gpio_irq
// Parametrised Wishbone GPIO with per-pin direction, atomic toggle and
// rising/falling edge interrupts latched in a write-1-to-clear STATUS.
//   wb_clk_i   : single clock for all logic
//   wb_rst_n_i : asynchronous active-low reset
//   wb         : Wishbone slave bus (see wb_gpio_irq_if)
//   gpio_i     : asynchronous pad inputs
//   gpio_o     : pad output values (OUT register)
//   gpio_oe_o  : pad output enables (OE register, 1 = drive)
//   irq_o      : level interrupt, OR of STATUS
// Register map (byte offsets): 00 IN, 04 OUT, 08 OE, 0C TGL, 10 RISE_EN,
// 14 FALL_EN, 18 STATUS (W1C), 1C INFO.
// ----------------------------------------------------------------------------
module wb_gpio_irq #(
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_OE    = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_gpio_irq_if.slave     wb,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    typedef enum logic [2:0] {
        REG_IN     = 3'd0,
        REG_OUT    = 3'd1,
        REG_OE     = 3'd2,
        REG_TGL    = 3'd3,
        REG_RISE   = 3'd4,
        REG_FALL   = 3'd5,
        REG_STATUS = 3'd6,
        REG_INFO   = 3'd7
    } reg_sel_e;

    localparam logic [31:0] INFO_VALUE = {22'd0, 2'(SYNC_STAGES - 1), 2'b00, 6'(WIDTH)};

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] wmask_w;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] clr_w;
    logic [31:0]      lane_mask_w;
    logic [31:0]      rdata_w;
    logic [31:0]      dat_q;
    logic             ack_q;
    logic             access_w;
    logic             write_w;
    reg_sel_e         reg_sel_w;
    logic             unused_w;

    // An access is accepted only when no ack is pending, which both gives one
    // ack per request and inserts an idle cycle between acks while stb stays high.
    assign access_w  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign write_w   = access_w & wb.wb_we_i;
    assign reg_sel_w = reg_sel_e'(wb.wb_adr_i[4:2]);

    // Byte lane gating applies to every write, including TGL and the STATUS clear.
    assign lane_mask_w = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                          {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign wmask_w = lane_mask_w[WIDTH-1:0];
    assign wdata_w = wb.wb_dat_i[WIDTH-1:0] & wmask_w;
    assign clr_w   = (write_w && reg_sel_w == REG_STATUS) ? wdata_w : '0;

    assign sync_w = sync_q[SYNC_STAGES-1];
    assign rise_w = sync_w & ~prev_q;
    assign fall_w = ~sync_w & prev_q;

    assign gpio_o      = out_q;
    assign gpio_oe_o   = oe_q;
    assign irq_o       = |status_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

    // Address bits outside [4:2], upper data bits and lane bits beyond WIDTH
    // are deliberately ignored.
    assign unused_w = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i, lane_mask_w};

    // Synchroniser chain for the asynchronous pads plus the one-cycle delayed
    // copy used for edge detection. Pins driven by us still feed this path.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_w;
        end
    end

    // Read data mux; bits at or above WIDTH read 0 and TGL always reads 0.
    always_comb begin
        rdata_w = '0;
        case (reg_sel_w)
            REG_IN:     rdata_w[WIDTH-1:0] = sync_w;
            REG_OUT:    rdata_w[WIDTH-1:0] = out_q;
            REG_OE:     rdata_w[WIDTH-1:0] = oe_q;
            REG_RISE:   rdata_w[WIDTH-1:0] = rise_en_q;
            REG_FALL:   rdata_w[WIDTH-1:0] = fall_en_q;
            REG_STATUS: rdata_w[WIDTH-1:0] = status_q;
            REG_INFO:   rdata_w = INFO_VALUE;
            default:    rdata_w = '0;
        endcase
    end

    // Bus handshake: ack and read data are registered together so dat_o is
    // valid exactly while ack is high and zero otherwise.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= access_w;
            dat_q <= access_w ? rdata_w : '0;
        end
    end

    // Control registers; writes land on the same edge that raises ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            out_q     <= RESET_OUT;
            oe_q      <= RESET_OE;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (write_w) begin
            case (reg_sel_w)
                REG_OUT:  out_q     <= (out_q & ~wmask_w) | wdata_w;
                REG_OE:   oe_q      <= (oe_q & ~wmask_w) | wdata_w;
                REG_TGL:  out_q     <= out_q ^ wdata_w;
                REG_RISE: rise_en_q <= (rise_en_q & ~wmask_w) | wdata_w;
                REG_FALL: fall_en_q <= (fall_en_q & ~wmask_w) | wdata_w;
                default:  ;
            endcase
        end
    end

    // Edge status: a new enabled event in the same cycle as a clear keeps the
    // bit set, so set terms are ORed in after the clear is applied.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~clr_w) | (rise_w & rise_en_q) | (fall_w & fall_en_q);
        end
    end

endmodule
